// File: rtl/key_load_seq.sv
// Serial key loader for a logic-locked netlist: shifts in a key plus an even
// parity bit, then commits the key to the locked netlist key inputs.
module key_load_seq #(
  parameter int KEY_W   = 6,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             kin_valid,
  input  logic             kin_data,
  output logic             kin_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             busy,
  output logic             err
);

  localparam int CW = (KEY_W > 1) ? $clog2(KEY_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_PARITY,
    S_ACTIVE,
    S_ERROR
  } state_t;

  state_t           r_state;
  state_t           w_state_n;
  logic [KEY_W-1:0] r_shadow;
  logic [KEY_W-1:0] w_shadow_n;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_n;
  logic [7:0]       r_timer;
  logic [7:0]       w_timer_n;
  logic [7:0]       w_timer_inc;
  logic [KEY_W-1:0] r_key;
  logic [KEY_W-1:0] w_key_n;
  logic             r_kvalid;
  logic             w_kvalid_n;
  logic             w_loading;
  logic             w_xfer;
  logic             w_stall_out;

  assign w_loading   = (r_state == S_SHIFT) || (r_state == S_PARITY);
  assign w_xfer      = kin_valid && w_loading;
  assign w_timer_inc = r_timer + 8'd1;
  assign w_stall_out = (w_timer_inc == 8'(TIMEOUT));

  always_comb begin
    w_state_n  = r_state;
    w_shadow_n = r_shadow;
    w_cnt_n    = r_cnt;
    w_timer_n  = r_timer;
    w_key_n    = r_key;
    w_kvalid_n = r_kvalid;
    if (start) begin
      // restart wins over any transfer offered in the same cycle
      w_state_n  = S_SHIFT;
      w_shadow_n = '0;
      w_cnt_n    = '0;
      w_timer_n  = '0;
      w_key_n    = '0;
      w_kvalid_n = 1'b0;
    end else begin
      unique case (r_state)
        S_SHIFT: begin
          if (w_xfer) begin
            w_shadow_n[r_cnt] = kin_data;
            w_timer_n         = '0;
            if (r_cnt == CW'(KEY_W - 1)) begin
              w_state_n = S_PARITY;
              w_cnt_n   = '0;
            end else begin
              w_cnt_n = r_cnt + 1'b1;
            end
          end else if (w_stall_out) begin
            w_state_n = S_ERROR;
            w_timer_n = '0;
          end else begin
            w_timer_n = w_timer_inc;
          end
        end
        S_PARITY: begin
          if (w_xfer) begin
            w_timer_n = '0;
            if ((^r_shadow ^ kin_data) == 1'b0) begin
              w_state_n  = S_ACTIVE;
              w_key_n    = r_shadow;
              w_kvalid_n = 1'b1;
            end else begin
              w_state_n = S_ERROR;
            end
          end else if (w_stall_out) begin
            w_state_n = S_ERROR;
            w_timer_n = '0;
          end else begin
            w_timer_n = w_timer_inc;
          end
        end
        S_ACTIVE: begin
          w_state_n = S_ACTIVE;
        end
        S_ERROR: begin
          w_key_n    = '0;
          w_kvalid_n = 1'b0;
        end
        default: begin
          w_key_n    = '0;
          w_kvalid_n = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_shadow <= '0;
      r_cnt    <= '0;
      r_timer  <= '0;
      r_key    <= '0;
      r_kvalid <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_shadow <= w_shadow_n;
      r_cnt    <= w_cnt_n;
      r_timer  <= w_timer_n;
      r_key    <= w_key_n;
      r_kvalid <= w_kvalid_n;
    end
  end

  assign kin_ready = w_loading;
  assign busy      = w_loading;
  assign err       = (r_state == S_ERROR);
  assign key_out   = r_key;
  assign key_valid = r_kvalid;

endmodule

// File: tb/tb_key_load_seq.sv
// Bench for key_load_seq: directed scenarios plus randomized loads checked
// against expectations built from the key/parity/stall rules.
module tb_key_load_seq;

  localparam int KEY_W   = 6;
  localparam int TIMEOUT = 16;
  localparam int OW      = KEY_W + 4;

  localparam logic [OW-1:0] E_IDLE = '0;
  localparam logic [OW-1:0] E_BUSY = {4'b1001, {KEY_W{1'b0}}};
  localparam logic [OW-1:0] E_ERR  = {4'b0100, {KEY_W{1'b0}}};

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             kin_valid = 1'b0;
  logic             kin_data = 1'b0;
  logic             kin_ready;
  logic [KEY_W-1:0] key_out;
  logic             key_valid;
  logic             busy;
  logic             err;

  int checks = 0;
  int failures = 0;

  wire [OW-1:0] w_obs = {busy, err, key_valid, kin_ready, key_out};

  always #5 clk = ~clk;

  key_load_seq #(.KEY_W(KEY_W), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .kin_valid(kin_valid),
    .kin_data (kin_data),
    .kin_ready(kin_ready),
    .key_out  (key_out),
    .key_valid(key_valid),
    .busy     (busy),
    .err      (err)
  );

  function automatic logic [OW-1:0] e_act(input logic [KEY_W-1:0] k);
    return {4'b0010, k};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input string nm);
    start     = 1'b1;
    kin_valid = 1'($urandom);
    kin_data  = 1'($urandom);
    tick();
    start     = 1'b0;
    kin_valid = 1'b0;
    checks++;
    if (w_obs !== E_BUSY) begin
      failures++;
      $display("FAIL %s_start got=%h exp=%h", nm, w_obs, E_BUSY);
    end
  endtask

  task automatic send_bit(input logic b);
    kin_valid = 1'b1;
    kin_data  = b;
    tick();
    kin_valid = 1'b0;
  endtask

  // Gaps before each transfer are drawn from [gmin,gmax] idle cycles.
  task automatic run_load(input logic [KEY_W-1:0] key, input logic par,
                          input int gmin, input int gmax, input string nm);
    logic [OW-1:0] exp;
    logic          b;
    int            g;
    for (int i = 0; i <= KEY_W; i++) begin
      b = (i < KEY_W) ? key[i] : par;
      g = int'($urandom_range(gmax, gmin));
      kin_valid = 1'b0;
      for (int j = 1; j <= g; j++) begin
        kin_data = 1'($urandom);
        tick();
        exp = (j >= TIMEOUT) ? E_ERR : E_BUSY;
        checks++;
        if (w_obs !== exp) begin
          failures++;
          $display("FAIL %s_gap bit=%0d idle=%0d got=%h exp=%h",
                   nm, i, j, w_obs, exp);
        end
        if (j >= TIMEOUT) return;
      end
      send_bit(b);
      if (i < KEY_W) exp = E_BUSY;
      else if (((^key) ^ par) == 1'b0) exp = e_act(key);
      else exp = E_ERR;
      checks++;
      if (w_obs !== exp) begin
        failures++;
        $display("FAIL %s_xfer bit=%0d got=%h exp=%h", nm, i, w_obs, exp);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    kin_valid = 1'b1;
    tick();
    checks++;
    if (w_obs !== E_IDLE) begin
      failures++;
      $display("FAIL reset got=%h exp=%h", w_obs, E_IDLE);
    end
    rst_n = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      kin_valid = 1'b1;
      kin_data  = 1'($urandom);
      tick();
      checks++;
      if (w_obs !== E_IDLE) begin
        failures++;
        $display("FAIL idle_ignore got=%h exp=%h", w_obs, E_IDLE);
      end
    end
    kin_valid = 1'b0;
  endtask

  task automatic test_good_load();
    do_start("good");
    run_load(6'h2D, 1'b0, 0, 0, "good");
  endtask

  task automatic test_bad_parity();
    do_start("badpar");
    run_load(6'h2D, 1'b1, 0, 0, "badpar");
    for (int i = 0; i < 3; i++) begin
      kin_valid = 1'($urandom);
      kin_data  = 1'($urandom);
      tick();
      checks++;
      if (w_obs !== E_ERR) begin
        failures++;
        $display("FAIL err_hold got=%h exp=%h", w_obs, E_ERR);
      end
    end
    kin_valid = 1'b0;
    do_start("recover");
    run_load(6'h2D, 1'b0, 0, 0, "recover");
  endtask

  task automatic test_stall();
    logic [OW-1:0] exp;
    do_start("stall");
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    for (int j = 1; j <= TIMEOUT; j++) begin
      tick();
      exp = (j == TIMEOUT) ? E_ERR : E_BUSY;
      checks++;
      if (w_obs !== exp) begin
        failures++;
        $display("FAIL stall idle=%0d got=%h exp=%h", j, w_obs, exp);
      end
    end
    do_start("gap5");
    run_load(6'h2D, 1'b0, 5, 5, "gap5");
  endtask

  task automatic test_restart();
    do_start("restart");
    for (int i = 0; i < 4; i++) send_bit(1'($urandom));
    start     = 1'b1;
    kin_valid = 1'b1;
    kin_data  = 1'b1;
    tick();
    start     = 1'b0;
    kin_valid = 1'b0;
    checks++;
    if (w_obs !== E_BUSY) begin
      failures++;
      $display("FAIL restart_same got=%h exp=%h", w_obs, E_BUSY);
    end
    run_load(6'h2D, 1'b0, 0, 0, "restart");
  endtask

  task automatic test_active_hold();
    for (int i = 0; i < 4; i++) begin
      kin_valid = 1'($urandom);
      kin_data  = 1'($urandom);
      tick();
      checks++;
      if (w_obs !== e_act(6'h2D)) begin
        failures++;
        $display("FAIL active_hold got=%h exp=%h", w_obs, e_act(6'h2D));
      end
    end
    kin_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    start = 1'b1;
    kin_valid = 1'b1;
    tick();
    rst_n = 1'b1;
    start = 1'b0;
    checks++;
    if (w_obs !== E_IDLE) begin
      failures++;
      $display("FAIL reset_mid got=%h exp=%h", w_obs, E_IDLE);
    end
    for (int i = 0; i < 2; i++) begin
      kin_data = 1'($urandom);
      tick();
      checks++;
      if (w_obs !== E_IDLE) begin
        failures++;
        $display("FAIL reset_needs_start got=%h exp=%h", w_obs, E_IDLE);
      end
    end
    kin_valid = 1'b0;
  endtask

  task automatic test_reload();
    do_start("reload");
    run_load(6'h3F, 1'b0, 0, 0, "reload");
  endtask

  task automatic test_random();
    logic [KEY_W-1:0] k;
    logic             p;
    int               gmax;
    for (int n = 0; n < 25; n++) begin
      k    = KEY_W'($urandom);
      p    = ($urandom_range(3, 0) == 0) ? ~(^k) : (^k);
      gmax = ($urandom_range(1, 0) == 0) ? 6 : TIMEOUT + 2;
      do_start("rand");
      run_load(k, p, 0, gmax, "rand");
    end
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_active_hold();
    test_reset_mid();
    test_bad_parity();
    test_stall();
    test_restart();
    test_reload();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout sim_time=%0t", $time);
    $fatal(1, "bench time limit");
  end

endmodule
